// File: rtl/fft_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_capture_ctrl
// Purpose  : Captures one AXI-Stream frame into the FFT input buffer as
//            interleaved RE/IM words, triggers streaming, forwards host writes.
// Revision : 1.0
// ============================================================================
module fft_capture_ctrl #(
    parameter int NFFT               = 3,
    parameter int POINT_SIZE         = 2**NFFT,
    parameter int ELEMENTS_ADDR_SIZE = $clog2(2*POINT_SIZE),
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          arm,
    input  logic                          continuous,
    input  logic                          abort,
    input  logic [63:0]                   s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic                          s_tlast,
    input  logic [ELEMENTS_ADDR_SIZE-1:0] host_wAddr,
    input  logic [31:0]                   host_wData,
    input  logic                          host_wEn,
    output logic                          host_wr_drop,
    output logic [ELEMENTS_ADDR_SIZE-1:0] buf_wAddr,
    output logic [31:0]                   buf_wData,
    output logic                          buf_wEn,
    output logic                          buf_trig,
    input  logic                          buf_streaming,
    output logic                          busy,
    output logic                          done,
    output logic                          framing_err,
    output logic [CNT_WIDTH-1:0]          frame_cnt
);

    localparam int                IDX_W  = ELEMENTS_ADDR_SIZE - 1;
    localparam logic [IDX_W-1:0]  c_LAST = IDX_W'(POINT_SIZE - 1);
    localparam logic [IDX_W-1:0]  c_ONE  = IDX_W'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CAPTURE_RE = 3'd1,
        ST_CAPTURE_IM = 3'd2,
        ST_TRIGGER    = 3'd3,
        ST_WAIT_START = 3'd4,
        ST_WAIT_END   = 3'd5
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [IDX_W-1:0]              r_idx;
    logic [31:0]                   r_im;
    logic                          r_abort_pend;
    logic                          r_drop;
    logic [ELEMENTS_ADDR_SIZE-1:0] r_waddr;
    logic [31:0]                   r_wdata;
    logic                          r_wen;
    logic                          r_ferr;
    logic [CNT_WIDTH-1:0]          r_cnt;
    logic                          w_is_last;
    logic                          w_stream_phase;
    logic                          w_frame_end;

    assign w_is_last      = (r_idx == c_LAST);
    assign w_stream_phase = (r_state == ST_TRIGGER) || (r_state == ST_WAIT_START) ||
                            (r_state == ST_WAIT_END);
    assign w_frame_end    = (r_state == ST_WAIT_END) && !buf_streaming;

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       if (arm && !abort && !buf_streaming) w_next = ST_CAPTURE_RE;
            ST_CAPTURE_RE: if (abort) w_next = ST_IDLE;
                           else if (s_tvalid) w_next = ST_CAPTURE_IM;
            ST_CAPTURE_IM: if (abort) w_next = ST_IDLE;
                           else if (w_is_last) w_next = ST_TRIGGER;
                           else w_next = ST_CAPTURE_RE;
            ST_TRIGGER:    w_next = ST_WAIT_START;
            ST_WAIT_START: if (buf_streaming) w_next = ST_WAIT_END;
            // An abort seen at the very end of the stream still suppresses re-arm.
            ST_WAIT_END:   if (!buf_streaming)
                               w_next = (continuous && !r_abort_pend && !abort) ?
                                        ST_CAPTURE_RE : ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_idx        <= '0;
            r_im         <= '0;
            r_abort_pend <= 1'b0;
            r_drop       <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_wen        <= 1'b0;
            r_ferr       <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_wen  <= 1'b0;
            r_drop <= host_wEn && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (host_wEn) begin
                        r_waddr <= host_wAddr;
                        r_wdata <= host_wData;
                        r_wen   <= 1'b1;
                    end
                    if (w_next == ST_CAPTURE_RE) begin
                        r_idx  <= '0;
                        r_ferr <= 1'b0;
                    end
                end
                ST_CAPTURE_RE: if (s_tvalid) begin
                    if (s_tlast != w_is_last) r_ferr <= 1'b1;
                    if (!abort) begin
                        r_waddr <= ELEMENTS_ADDR_SIZE'({r_idx, 1'b0});
                        r_wdata <= s_tdata[31:0];
                        r_wen   <= 1'b1;
                        r_im    <= s_tdata[63:32];
                    end
                end
                ST_CAPTURE_IM: if (!abort) begin
                    r_waddr <= ELEMENTS_ADDR_SIZE'({r_idx, 1'b1});
                    r_wdata <= r_im;
                    r_wen   <= 1'b1;
                    if (!w_is_last) r_idx <= r_idx + c_ONE;
                end
                ST_WAIT_END: if (!buf_streaming) begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (w_next == ST_CAPTURE_RE) r_idx <= '0;
                end
                default: ;
            endcase
            if (w_next == ST_IDLE)              r_abort_pend <= 1'b0;
            else if (abort && w_stream_phase)   r_abort_pend <= 1'b1;
        end
    end

    assign s_tready     = (r_state == ST_CAPTURE_RE);
    assign buf_trig     = (r_state == ST_TRIGGER);
    assign busy         = (r_state != ST_IDLE);
    assign done         = w_frame_end;
    assign host_wr_drop = r_drop;
    assign buf_wAddr    = r_waddr;
    assign buf_wData    = r_wdata;
    assign buf_wEn      = r_wen;
    assign framing_err  = r_ferr;
    assign frame_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_capture_ctrl
// Purpose  : Self-checking bench for fft_capture_ctrl with a write scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fft_capture_ctrl;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          resetn, arm, continuous, abort;
    logic [63:0]   s_tdata;
    logic          s_tvalid, s_tready, s_tlast;
    logic [AW-1:0] host_wAddr;
    logic [31:0]   host_wData;
    logic          host_wEn, host_wr_drop;
    logic [AW-1:0] buf_wAddr;
    logic [31:0]   buf_wData;
    logic          buf_wEn, buf_trig, buf_streaming;
    logic          busy, done, framing_err;
    logic [15:0]   frame_cnt;

    int n_pass = 0, n_total = 0, trig_cnt = 0, exp_cnt = 0, sd;
    logic [AW+31:0] exp_q[$];

    fft_capture_ctrl #(.NFFT(3), .CNT_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn), .arm(arm), .continuous(continuous), .abort(abort),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .host_wAddr(host_wAddr), .host_wData(host_wData), .host_wEn(host_wEn),
        .host_wr_drop(host_wr_drop), .buf_wAddr(buf_wAddr), .buf_wData(buf_wData),
        .buf_wEn(buf_wEn), .buf_trig(buf_trig), .buf_streaming(buf_streaming),
        .busy(busy), .done(done), .framing_err(framing_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: every buffer write must match the oldest expected write.
    always @(negedge clk) begin
        if (buf_wEn) begin
            logic [AW+31:0] e;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL wr_unexpected: got addr=%0d data=%h, expected no write", buf_wAddr, buf_wData);
            end else begin
                e = exp_q.pop_front();
                if ({buf_wAddr, buf_wData} !== e)
                    $display("FAIL wr_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                             buf_wAddr, buf_wData, e[AW+31:32], e[31:0]);
                else n_pass++;
            end
        end
        if (buf_trig) trig_cnt++;
    end

    // Buffer model: starts streaming 3..12 cycles after a trigger, streams 4 cycles.
    initial begin
        buf_streaming = 1'b0;
        forever begin
            @(negedge clk);
            if (buf_trig) begin
                sd = $urandom_range(3, 12);
                repeat (sd) @(posedge clk);
                #2 buf_streaming = 1'b1;
                repeat (4) @(posedge clk);
                #2 buf_streaming = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1);
    end

    task automatic arm_pulse();
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
    endtask

    task automatic send_frame(input int nsamp, input int stall_after, input int tlast_at,
                              output bit ok);
        ok = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < nsamp; k++) begin
            int cyc;
            s_tdata  = {32'h100 + 32'(k), 32'(k)};
            s_tvalid = 1'b1;
            s_tlast  = (k == tlast_at);
            exp_q.push_back({AW'(2*k), 32'(k)});
            exp_q.push_back({AW'(2*k+1), 32'h100 + 32'(k)});
            cyc = 0;
            @(negedge clk);
            while (!s_tready && cyc < 40) begin @(negedge clk); cyc++; end
            if (!s_tready) begin ok = 1'b0; break; end
            @(posedge clk); #1;
            if (k == stall_after) begin
                s_tvalid = 1'b0;
                repeat (3) @(negedge clk);
                n_total++;
                if (s_tready !== 1'b1) $display("FAIL stall_tready: got %b, expected 1", s_tready);
                else n_pass++;
                @(posedge clk); #1;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_trig(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (buf_trig) ok = 1'b1;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; arm = 0; continuous = 0; abort = 0; s_tdata = '0; s_tvalid = 0;
        s_tlast = 0; host_wAddr = '0; host_wData = '0; host_wEn = 0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({s_tready, buf_trig, buf_wEn, busy, done, framing_err, host_wr_drop} !== 7'b0)
            $display("FAIL reset_flags: got %b, expected 0000000",
                     {s_tready, buf_trig, buf_wEn, busy, done, framing_err, host_wr_drop});
        else n_pass++;
        n_total++;
        if (frame_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d, expected 0", frame_cnt);
        else n_pass++;
        n_total++;
        if ({buf_wAddr, buf_wData} !== '0)
            $display("FAIL reset_bus: got addr=%0d data=%h, expected 0", buf_wAddr, buf_wData);
        else n_pass++;
        @(posedge clk); #1 resetn = 1'b1;
    endtask

    task automatic run_single(input string nm, input int stall_after, input int tlast_at);
        bit ok;
        arm_pulse();
        send_frame(8, stall_after, tlast_at, ok);
        wait_trig(ok);
        n_total++;
        if (!ok) $display("FAIL %s_trig: got no trigger, expected trigger", nm);
        else if (!(buf_wEn === 1'b1 && buf_wAddr === AW'(15)))
            $display("FAIL %s_trig_wr: got wEn=%b addr=%0d, expected wEn=1 addr=15", nm, buf_wEn, buf_wAddr);
        else n_pass++;
        wait_done(ok);
        n_total++;
        if (!ok) $display("FAIL %s_done: got no done, expected done", nm);
        else n_pass++;
        exp_cnt++;
        @(negedge clk);
        n_total++;
        if ({frame_cnt, busy, done} !== {16'(exp_cnt), 2'b00})
            $display("FAIL %s_end: got cnt=%0d busy=%b done=%b, expected cnt=%0d busy=0 done=0",
                     nm, frame_cnt, busy, done, exp_cnt);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL %s_writes: got %0d missing, expected 0", nm, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_basic();
        run_single("basic", -1, 7);
    endtask

    task automatic test_stall();
        run_single("stall", 4, 7);
    endtask

    task automatic test_host();
        int cyc;
        exp_q.push_back({AW'(5), 32'hDEADBEEF});
        @(posedge clk); #1 host_wAddr = AW'(5); host_wData = 32'hDEADBEEF; host_wEn = 1'b1;
        @(posedge clk); #1 host_wEn = 1'b0;
        @(negedge clk);
        n_total++;
        if (host_wr_drop !== 1'b0) $display("FAIL host_idle_drop: got %b, expected 0", host_wr_drop);
        else n_pass++;
        // arm and abort together: stays idle
        @(posedge clk); #1 arm = 1'b1; abort = 1'b1;
        @(posedge clk); #1 arm = 1'b0; abort = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL arm_abort: got busy=%b, expected 0", busy);
        else n_pass++;
        arm_pulse();
        @(posedge clk); #1;
        s_tdata = {32'h100, 32'h0}; s_tvalid = 1'b1; s_tlast = 1'b0;
        exp_q.push_back({AW'(0), 32'h0});
        exp_q.push_back({AW'(1), 32'h100});
        cyc = 0;
        @(negedge clk);
        while (!s_tready && cyc < 20) begin @(negedge clk); cyc++; end
        @(posedge clk); #1 s_tvalid = 1'b0; host_wEn = 1'b1;
        @(posedge clk); #1 host_wEn = 1'b0;
        @(negedge clk);
        n_total++;
        if (host_wr_drop !== 1'b1) $display("FAIL host_busy_drop: got %b, expected 1", host_wr_drop);
        else n_pass++;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, frame_cnt} !== {1'b0, 16'(exp_cnt)} || exp_q.size() != 0)
            $display("FAIL capture_abort: got busy=%b cnt=%0d pending=%0d, expected busy=0 cnt=%0d pending=0",
                     busy, frame_cnt, exp_q.size(), exp_cnt);
        else n_pass++;
    endtask

    task automatic test_framing();
        run_single("framing", -1, 4);
        n_total++;
        if (framing_err !== 1'b1) $display("FAIL framing_set: got %b, expected 1", framing_err);
        else n_pass++;
        arm_pulse();
        @(negedge clk);
        n_total++;
        if ({framing_err, s_tready} !== 2'b01)
            $display("FAIL framing_clr: got err=%b tready=%b, expected err=0 tready=1", framing_err, s_tready);
        else n_pass++;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL framing_abort: got busy=%b, expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_continuous();
        bit ok;
        continuous = 1'b1;
        arm_pulse();
        for (int f = 0; f < 3; f++) begin
            send_frame(8, -1, 7, ok);
            wait_trig(ok);
            n_total++;
            if (!ok) $display("FAIL cont_trig%0d: got no trigger, expected trigger", f);
            else n_pass++;
            if (f == 2) begin
                for (int c = 0; c < 30; c++) begin
                    @(posedge clk); #1;
                    if (buf_streaming) break;
                end
                abort = 1'b1;
                @(posedge clk); #1 abort = 1'b0;
            end
            wait_done(ok);
            n_total++;
            if (!ok) $display("FAIL cont_done%0d: got no done, expected done", f);
            else n_pass++;
            exp_cnt++;
            @(negedge clk);
            n_total++;
            if (f < 2) begin
                if ({frame_cnt, s_tready} !== {16'(exp_cnt), 1'b1})
                    $display("FAIL cont_rearm%0d: got cnt=%0d tready=%b, expected cnt=%0d tready=1",
                             f, frame_cnt, s_tready, exp_cnt);
                else n_pass++;
            end else begin
                if ({frame_cnt, busy} !== {16'(exp_cnt), 1'b0})
                    $display("FAIL cont_abort: got cnt=%0d busy=%b, expected cnt=%0d busy=0",
                             frame_cnt, busy, exp_cnt);
                else n_pass++;
            end
        end
        continuous = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int trig0;
        arm_pulse();
        send_frame(3, -1, -1, ok);
        resetn = 1'b0;
        void'(exp_q.pop_back());
        trig0 = trig_cnt;
        repeat (2) @(negedge clk);
        n_total++;
        if ({s_tready, buf_trig, buf_wEn, busy, done, framing_err, host_wr_drop, frame_cnt} !== '0)
            $display("FAIL midreset_out: got flags=%b cnt=%0d, expected all 0",
                     {s_tready, buf_trig, buf_wEn, busy, done, framing_err, host_wr_drop}, frame_cnt);
        else n_pass++;
        @(posedge clk); #1 resetn = 1'b1;
        repeat (5) @(negedge clk);
        n_total++;
        if (trig_cnt != trig0) $display("FAIL midreset_trig: got %0d triggers, expected 0", trig_cnt - trig0);
        else n_pass++;
        exp_cnt = 0;
        run_single("rearm", -1, 7);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_host();
        test_framing();
        test_continuous();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
